wt_dcache_rd_arb: RTL
=====================

WT_DCACHE_RD_ARB -- requirements
Module: wt_dcache_rd_arb

Interface
REQ-001 SHALL have parameter NumPorts, default 3: number of read requesters (legal 2..8).
REQ-002 SHALL have parameter IdxWidth, default DCACHE_CL_IDX_WIDTH: cache line index width.
REQ-003 SHALL have parameter OffWidth, default DCACHE_OFFSET_WIDTH: line offset width.
REQ-004 SHALL have parameter TagWidth, default DCACHE_TAG_WIDTH: tag width.
REQ-005 SHALL have parameter StarveLimit, default 15: consecutive denied cycles before a low-priority port is promoted (legal 1..255).
REQ-006 SHALL have port clk_i, input, 1, clock. One clock; all state on rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset. Asynchronous, active-low.
REQ-008 SHALL have port flush_arb_i, input, 1, synchronous clear of arbitration state.
REQ-009 SHALL have port wr_cl_vld_i, input, 1, cacheline write in progress; blocks all read grants.
REQ-010 SHALL have port rd_req_i, input, NumPorts, per-port read request.
REQ-011 SHALL have port rd_prio_i, input, NumPorts, 1 = high-priority port.
REQ-012 SHALL have port rd_tag_only_i, input, NumPorts, tag-only lookup flag.
REQ-013 SHALL have ports rd_idx_i / rd_off_i / rd_tag_i, input, NumPorts x IdxWidth / OffWidth / TagWidth, per-port address fields.
REQ-014 SHALL have port rd_ack_o, output, NumPorts, one-hot grant.
REQ-015 SHALL have ports mem_req_o (1), mem_idx_o (IdxWidth), mem_off_o (OffWidth), mem_tag_o (TagWidth), mem_tag_only_o (1), output, granted request to the arrays.
REQ-016 SHALL have ports rsp_vld_o (1), rsp_port_o ($clog2(NumPorts)), rsp_tag_only_o (1), rsp_tag_o (TagWidth), output, registered response tag for the hit-compare stage.

Function
REQ-017 SHALL grant at most one port per cycle; rd_ack_o SHALL be zero when wr_cl_vld_i=1 or rd_req_i=0.
REQ-018 SHALL produce rd_ack_o and mem_* combinationally in the request cycle (zero-latency grant); mem_req_o = |rd_ack_o.
REQ-019 SHALL select by class order: starving low-priority ports, then high-priority requesters, then other low-priority requesters.
REQ-020 SHALL pick within a class by round-robin: first requesting port at or after that class's pointer, wrapping NumPorts-1 -> 0.
REQ-021 SHALL keep separate pointers for high and low classes; on a grant in a class, that pointer SHALL become (granted+1) mod NumPorts; starving grants update the low pointer.
REQ-022 SHALL keep, per low-priority port, a saturating counter: +1 when requesting and not granted while another port is granted; held when grants are blocked by wr_cl_vld_i; cleared on grant or when rd_req_i drops.
REQ-023 SHALL treat a port as starving when its counter equals StarveLimit; counters saturate there.
REQ-024 SHALL ignore counters of ports with rd_prio_i=1 (held at 0).
REQ-025 SHALL drive mem_* fields from the granted port; when no grant, mem_* fields SHALL be 0.
REQ-026 SHALL register rsp_vld_o = mem_req_o, rsp_port_o = granted index, rsp_tag_only_o and rsp_tag_o from the grant cycle; exactly 1-cycle latency; rsp_* other than rsp_vld_o hold when no grant.
REQ-027 SHALL accept requests withdrawn before grant without side effects other than counter clear.
REQ-028 SHALL, on flush_arb_i=1, clear both pointers and all counters at the next edge; the grant in that cycle is still issued and its rsp_vld_o still asserts.
REQ-029 SHALL, with wr_cl_vld_i and flush_arb_i simultaneous, issue no grant and clear state.

Reset
REQ-030 SHALL, on rst_ni=0 (asynchronous), set pointers=0, counters=0, rsp_vld_o=0, rsp_port_o=0, rsp_tag_only_o=0, rsp_tag_o=0; combinational outputs follow inputs.
REQ-031 SHALL, on reset asserted mid-operation, drop any pending response (rsp_vld_o=0 next observed cycle) with no grant replay.

Verification
REQ-032 SHALL cover: NumPorts=3, rd_prio=011, rd_req=111 for 4 cycles -> rd_ack sequence 001,010,001,010; rsp_port_o 0,1,0,1 each one cycle later.
REQ-033 SHALL cover: same setup, StarveLimit=3, continuous requests -> port 2 granted on cycle 4 (after 3 denials), counter cleared, then port 0 or 1 resumes per round-robin.
REQ-034 SHALL cover: wr_cl_vld_i=1 for 5 cycles with rd_req=111 -> rd_ack_o=000, mem_req_o=0, port 2 counter unchanged.
REQ-035 SHALL cover: NumPorts=4, all low priority, rd_req=1111 -> grants 0,1,2,3,0 (wrap-around).
REQ-036 SHALL cover: flush_arb_i pulse after high pointer reaches 2 -> next high grant starts from port 0; rsp_vld_o of flush-cycle grant = 1.
REQ-037 SHALL cover: rst_ni low one cycle after a grant -> rsp_vld_o=0 immediately, pointers reset, first grant after reset to port 0.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb: zero-latency read-port arbiter in front of the dcache arrays.
// Three grant classes are checked in order: starving low-priority ports, then
// high-priority ports, then the remaining low-priority ports. Each class picks
// round-robin from its own pointer.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_arb_i               clears pointers and starvation counters at the next edge
//   wr_cl_vld_i               cacheline write in progress; blocks every read grant
//   rd_req/prio/tag_only_i    per-port request, priority class and tag-only flag
//   rd_idx/off/tag_i          per-port address fields
//   rd_ack_o, mem_*_o         combinational one-hot grant and the granted request
//   rsp_*_o                   grant registered for the hit-compare stage, 1-cycle latency
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned IdxWidth    = 8,
  parameter int unsigned OffWidth    = 4,
  parameter int unsigned TagWidth    = 16,
  parameter int unsigned StarveLimit = 15
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_arb_i,
  input  logic                               wr_cl_vld_i,
  input  logic [NumPorts-1:0]                rd_req_i,
  input  logic [NumPorts-1:0]                rd_prio_i,
  input  logic [NumPorts-1:0]                rd_tag_only_i,
  input  logic [NumPorts-1:0][IdxWidth-1:0]  rd_idx_i,
  input  logic [NumPorts-1:0][OffWidth-1:0]  rd_off_i,
  input  logic [NumPorts-1:0][TagWidth-1:0]  rd_tag_i,
  output logic [NumPorts-1:0]                rd_ack_o,
  output logic                               mem_req_o,
  output logic [IdxWidth-1:0]                mem_idx_o,
  output logic [OffWidth-1:0]                mem_off_o,
  output logic [TagWidth-1:0]                mem_tag_o,
  output logic                               mem_tag_only_o,
  output logic                               rsp_vld_o,
  output logic [$clog2(NumPorts)-1:0]        rsp_port_o,
  output logic                               rsp_tag_only_o,
  output logic [TagWidth-1:0]                rsp_tag_o
);

  localparam int unsigned PtrW = $clog2(NumPorts);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  logic [PtrW-1:0]                hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
  logic [NumPorts-1:0][CntW-1:0]  cnt_q, cnt_d;
  logic [NumPorts-1:0]            starve, hi_req, lo_req;
  logic                           gnt_vld, gnt_hi;
  logic [PtrW-1:0]                gnt_idx;

  // First set bit of req at or after ptr, wrapping at NumPorts.
  function automatic logic [PtrW-1:0] rr_pick(input logic [NumPorts-1:0] req,
                                              input logic [PtrW-1:0]     ptr);
    logic [PtrW-1:0] sel;
    logic            hit;
    int unsigned     j;
    sel = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      j = (32'(ptr) + k) % NumPorts;
      if (!hit && req[j]) begin
        hit = 1'b1;
        sel = PtrW'(j);
      end
    end
    return sel;
  endfunction

  // (idx + 1) mod NumPorts.
  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] idx);
    int unsigned t;
    t = 32'(idx) + 32'd1;
    if (t >= NumPorts) t = 0;
    return PtrW'(t);
  endfunction

  // Class selection and the combinational grant.
  always_comb begin
    starve         = '0;
    hi_req         = rd_req_i & rd_prio_i;
    lo_req         = rd_req_i & ~rd_prio_i;
    gnt_vld        = 1'b0;
    gnt_hi         = 1'b0;
    gnt_idx        = '0;
    rd_ack_o       = '0;
    mem_req_o      = 1'b0;
    mem_idx_o      = '0;
    mem_off_o      = '0;
    mem_tag_o      = '0;
    mem_tag_only_o = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      starve[i] = lo_req[i] && (cnt_q[i] == CntMax);
    end
    if (!wr_cl_vld_i) begin
      if (|starve) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_pick(starve, lo_ptr_q);
      end else if (|hi_req) begin
        gnt_vld = 1'b1;
        gnt_hi  = 1'b1;
        gnt_idx = rr_pick(hi_req, hi_ptr_q);
      end else if (|lo_req) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_pick(lo_req, lo_ptr_q);
      end
    end
    if (gnt_vld) begin
      rd_ack_o[gnt_idx] = 1'b1;
      mem_req_o         = 1'b1;
      mem_idx_o         = rd_idx_i[gnt_idx];
      mem_off_o         = rd_off_i[gnt_idx];
      mem_tag_o         = rd_tag_i[gnt_idx];
      mem_tag_only_o    = rd_tag_only_i[gnt_idx];
    end
  end

  // Pointer and starvation-counter next state.
  always_comb begin
    hi_ptr_d = hi_ptr_q;
    lo_ptr_d = lo_ptr_q;
    cnt_d    = cnt_q;
    if (gnt_vld) begin
      if (gnt_hi) hi_ptr_d = next_idx(gnt_idx);
      else        lo_ptr_d = next_idx(gnt_idx);
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rd_prio_i[i] || !rd_req_i[i] || (gnt_vld && gnt_idx == PtrW'(i))) begin
        cnt_d[i] = '0;
      end else if (gnt_vld && cnt_q[i] != CntMax) begin
        // Only counts a cycle lost to another port; write-blocked cycles hold.
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    if (flush_arb_i) begin
      hi_ptr_d = '0;
      lo_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Arbitration state and registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_ptr_q       <= '0;
      lo_ptr_q       <= '0;
      cnt_q          <= '0;
      rsp_vld_o      <= 1'b0;
      rsp_port_o     <= '0;
      rsp_tag_only_o <= 1'b0;
      rsp_tag_o      <= '0;
    end else begin
      hi_ptr_q  <= hi_ptr_d;
      lo_ptr_q  <= lo_ptr_d;
      cnt_q     <= cnt_d;
      rsp_vld_o <= gnt_vld;
      if (gnt_vld) begin
        rsp_port_o     <= gnt_idx;
        rsp_tag_only_o <= rd_tag_only_i[gnt_idx];
        rsp_tag_o      <= rd_tag_i[gnt_idx];
      end
    end
  end

endmodule
